// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back stage of the pipeline.
//
// Accepts one instruction per cycle from the MEM stage. For an instruction
// that is not a load, the register-bank write comes out in the next cycle.
// For a load, the stage waits for the returning memory data, extends it to
// 64 bits and then writes it. Every completed instruction increments
// retireCount, including writes to x31 (XZR), which are discarded.
//
// Handshake: memValid/memReady follow valid/ready rules. A transfer happens
// on a rising clock edge where memValid && memReady are both 1. memValid does
// not depend on memReady. memReady is 0 while a load waits for data and
// while rst is high.
//
// Ports
//   clk            in   clock; all state changes on the rising edge
//   rst            in   synchronous active-high reset
//   memValid       in   MEM stage presents an instruction
//   memReady       out  stage can accept an instruction this cycle
//   memToReg       in   instruction is a load
//   regWriteIn     in   instruction writes a destination register
//   rdIn[4:0]      in   destination register index
//   aluResult[63:0] in  result for instructions that are not loads
//   loadSize[1:0]  in   00 byte, 01 half, 10 word, 11 doubleword
//   loadSigned     in   1 = sign-extend, 0 = zero-extend
//   memRdata[63:0] in   load return data, LSB-aligned
//   memRdataValid  in   memRdata valid this cycle
//   regWrite       out  register-bank write enable (one cycle per instr)
//   writeReg[4:0]  out  register-bank write index
//   writeData[63:0] out register-bank write data
//   retireCount[31:0] out count of completed instructions (wraps)
//   o_dbg_state[1:0] out current FSM state (debug)
// -----------------------------------------------------------------------------
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        memValid,
    output logic        memReady,
    input  logic        memToReg,
    input  logic        regWriteIn,
    input  logic [4:0]  rdIn,
    input  logic [63:0] aluResult,
    input  logic [1:0]  loadSize,
    input  logic        loadSigned,
    input  logic [63:0] memRdata,
    input  logic        memRdataValid,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [63:0] writeData,
    output logic [31:0] retireCount,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]  r_state;
    logic        r_reg_write;
    logic [4:0]  r_write_reg;
    logic [63:0] r_write_data;
    logic [31:0] r_retire_count;

    // Fields of a load held while it waits for its data. For instructions
    // that are not loads, the result is captured directly into the output
    // registers at transfer time, so those registers also act as the
    // holding place for rd and aluResult.
    logic        r_hold_we;
    logic [4:0]  r_hold_rd;
    logic [1:0]  r_hold_size;
    logic        r_hold_signed;

    logic        w_xfer;
    logic        w_in_we;
    logic [63:0] w_load_data;

    assign memReady = !rst && (r_state != ST_WAIT);
    assign w_xfer   = memValid && memReady;

    // A write to x31 is still completed and counted, but the enable is
    // dropped so that the register bank never sees it.
    assign w_in_we  = regWriteIn && (rdIn != 5'd31);

    always_comb begin
        w_load_data = memRdata;
        case (r_hold_size)
            2'b00:   w_load_data = {{56{r_hold_signed & memRdata[7]}},  memRdata[7:0]};
            2'b01:   w_load_data = {{48{r_hold_signed & memRdata[15]}}, memRdata[15:0]};
            2'b10:   w_load_data = {{32{r_hold_signed & memRdata[31]}}, memRdata[31:0]};
            default: w_load_data = memRdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_reg_write    <= 1'b0;
            r_write_reg    <= 5'd0;
            r_write_data   <= 64'd0;
            r_retire_count <= 32'd0;
            r_hold_we      <= 1'b0;
            r_hold_rd      <= 5'd0;
            r_hold_size    <= 2'd0;
            r_hold_signed  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WRITE: begin
                    r_reg_write <= 1'b0;
                    if (w_xfer) begin
                        if (memToReg) begin
                            r_state       <= ST_WAIT;
                            r_hold_we     <= w_in_we;
                            r_hold_rd     <= rdIn;
                            r_hold_size   <= loadSize;
                            r_hold_signed <= loadSigned;
                        end else begin
                            // The output registers are loaded here so that
                            // the write is visible in the very next cycle.
                            r_state        <= ST_WRITE;
                            r_reg_write    <= w_in_we;
                            r_write_reg    <= rdIn;
                            r_write_data   <= aluResult;
                            r_retire_count <= r_retire_count + 32'd1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    r_reg_write <= 1'b0;
                    if (memRdataValid) begin
                        r_state        <= ST_WRITE;
                        r_reg_write    <= r_hold_we;
                        r_write_reg    <= r_hold_rd;
                        r_write_data   <= w_load_data;
                        r_retire_count <= r_retire_count + 32'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_reg_write <= 1'b0;
                end
            endcase
        end
    end

    assign regWrite    = r_reg_write;
    assign writeReg    = r_write_reg;
    assign writeData   = r_write_data;
    assign retireCount = r_retire_count;
    assign o_dbg_state = r_state;

endmodule
